// File: rtl/debounce_bank.sv
// Multi-channel push-button conditioner: two-flop synchroniser, stable-sample
// debounce, press/release strobes and an optional per-channel auto-repeat strobe.
//
// Repeat FSM states (one per channel):
//   state      | meaning
//   RPT_IDLE   | not repeating; waits for a press with repeat enabled
//   RPT_DELAY  | held since press; counting toward the first repeat strobe
//   RPT_RUN    | repeating; one strobe every REPEAT_PERIOD cycles
module debounce_bank #(
   parameter int CHANNELS      = 2,
   parameter int ACTIVE_LOW    = 1,
   parameter int STABLE_CYCLES = 500000,
   parameter int REPEAT_DELAY  = 5000000,
   parameter int REPEAT_PERIOD = 1000000
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [CHANNELS-1:0] i_btn,
   input  logic [CHANNELS-1:0] i_repeat_en,
   output logic [CHANNELS-1:0] o_level,
   output logic [CHANNELS-1:0] o_press,
   output logic [CHANNELS-1:0] o_release,
   output logic [CHANNELS-1:0] o_repeat,
   output logic                o_any_press
);

   localparam int SW   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

   localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
   localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
   localparam logic          IDLE_RAW    = (ACTIVE_LOW != 0);

   typedef enum logic [1:0] {
      RPT_IDLE  = 2'd0,
      RPT_DELAY = 2'd1,
      RPT_RUN   = 2'd2
   } rpt_state_t;

   logic [CHANNELS-1:0] sync1;
   logic [CHANNELS-1:0] sync2;
   logic [CHANNELS-1:0] btn_s;

   // Sync flops reset to the unpressed raw value so deassertion never looks like a press.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         sync1 <= {CHANNELS{IDLE_RAW}};
         sync2 <= {CHANNELS{IDLE_RAW}};
      end else begin
         sync1 <= i_btn;
         sync2 <= sync1;
      end
   end

   assign btn_s = sync2 ^ {CHANNELS{IDLE_RAW}};

   for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
      logic [SW-1:0] cnt;
      logic          level_q;
      logic          press_q;
      logic          release_q;
      rpt_state_t    state;
      rpt_state_t    state_nxt;
      logic [RW-1:0] rcnt;
      logic [RW-1:0] rcnt_nxt;
      logic          rpt_hit;

      always_ff @(posedge i_clk or negedge i_reset) begin
         if (!i_reset) begin
            cnt       <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            if (btn_s[ch] == level_q) begin
               cnt <= '0;
            end else if (cnt == STABLE_LAST) begin
               cnt       <= '0;
               level_q   <= btn_s[ch];
               press_q   <= btn_s[ch];
               release_q <= ~btn_s[ch];
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end

      always_ff @(posedge i_clk or negedge i_reset) begin
         if (!i_reset) begin
            state <= RPT_IDLE;
            rcnt  <= '0;
         end else begin
            state <= state_nxt;
            rcnt  <= rcnt_nxt;
         end
      end

      // The strobe is decoded from the registered count so the first repeat lands
      // exactly REPEAT_DELAY cycles after the press strobe.
      always_comb begin
         state_nxt = state;
         rcnt_nxt  = rcnt;
         rpt_hit   = 1'b0;
         if (!level_q || !i_repeat_en[ch]) begin
            state_nxt = RPT_IDLE;
            rcnt_nxt  = '0;
         end else begin
            case (state)
               RPT_IDLE: begin
                  if (press_q) begin
                     state_nxt = RPT_DELAY;
                     rcnt_nxt  = '0;
                  end
               end
               RPT_DELAY: begin
                  if (rcnt == DELAY_LAST) begin
                     rpt_hit   = 1'b1;
                     rcnt_nxt  = '0;
                     state_nxt = RPT_RUN;
                  end else begin
                     rcnt_nxt = rcnt + 1'b1;
                  end
               end
               RPT_RUN: begin
                  if (rcnt == PERIOD_LAST) begin
                     rpt_hit  = 1'b1;
                     rcnt_nxt = '0;
                  end else begin
                     rcnt_nxt = rcnt + 1'b1;
                  end
               end
               default: begin
                  state_nxt = RPT_IDLE;
                  rcnt_nxt  = '0;
               end
            endcase
         end
      end

      assign o_level[ch]   = level_q;
      assign o_press[ch]   = press_q;
      assign o_release[ch] = release_q;
      assign o_repeat[ch]  = rpt_hit;
   end

   assign o_any_press = |o_press;

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank: stimulus queues expected strobe events,
// a negedge monitor pops and compares them as the DUT emits strobes.
module tb_debounce_bank;

   logic       i_clk;
   logic       i_reset;
   logic [1:0] i_btn;
   logic [1:0] i_repeat_en;
   logic [1:0] o_level;
   logic [1:0] o_press;
   logic [1:0] o_release;
   logic [1:0] o_repeat;
   logic       o_any_press;

   debounce_bank #(
      .CHANNELS      (2),
      .ACTIVE_LOW    (1),
      .STABLE_CYCLES (8),
      .REPEAT_DELAY  (20),
      .REPEAT_PERIOD (5)
   ) dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_btn       (i_btn),
      .i_repeat_en (i_repeat_en),
      .o_level     (o_level),
      .o_press     (o_press),
      .o_release   (o_release),
      .o_repeat    (o_repeat),
      .o_any_press (o_any_press)
   );

   typedef struct {
      int         cyc;
      logic [1:0] press;
      logic [1:0] rel;
      logic [1:0] rpt;
      logic [1:0] lvl;
   } evt_t;

   evt_t exp_q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   passes = 0;

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   always @(posedge i_clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic void expect_evt(input int c, input logic [1:0] p, input logic [1:0] r,
                                      input logic [1:0] rp, input logic [1:0] l);
      evt_t e;
      e.cyc = c; e.press = p; e.rel = r; e.rpt = rp; e.lvl = l;
      exp_q.push_back(e);
   endfunction

   // Monitor: flag events that should already have appeared, then match any strobe.
   always @(negedge i_clk) begin
      evt_t e;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         e = exp_q.pop_front();
         chk("missed_event_cycle", 32'(cyc), 32'(e.cyc));
      end
      if ((o_press | o_release | o_repeat) != 2'b00) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_strobe", {26'd0, o_press, o_release, o_repeat}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("evt_cycle", 32'(cyc), 32'(e.cyc));
            chk("evt_press", 32'(o_press), 32'(e.press));
            chk("evt_release", 32'(o_release), 32'(e.rel));
            chk("evt_repeat", 32'(o_repeat), 32'(e.rpt));
            chk("evt_level", 32'(o_level), 32'(e.lvl));
            chk("evt_any_press", 32'(o_any_press), 32'(e.press != 2'b00));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge i_clk);
      #2;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_level"}, 32'(o_level), 32'd0);
      chk({tag, "_press"}, 32'(o_press), 32'd0);
      chk({tag, "_release"}, 32'(o_release), 32'd0);
      chk({tag, "_repeat"}, 32'(o_repeat), 32'd0);
      chk({tag, "_any"}, 32'(o_any_press), 32'd0);
   endtask

   task automatic assert_reset(input string tag);
      exp_q.delete();
      i_reset = 1'b0;
      #1;
      check_all_zero(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p;
      i_reset     = 1'b0;
      i_btn       = 2'b11;
      i_repeat_en = 2'b00;
      step(3);
      check_all_zero("reset");
      i_reset = 1'b1;
      step(5);

      // single press on channel 0, then release
      i_btn[0] = 1'b0;
      expect_evt(cyc + 10, 2'b01, 2'b00, 2'b00, 2'b01);
      step(30);
      i_btn[0] = 1'b1;
      expect_evt(cyc + 10, 2'b00, 2'b01, 2'b00, 2'b00);
      step(30);

      // bounce: 7 low / 1 high x5, then a clean hold
      for (int i = 0; i < 5; i++) begin
         i_btn[0] = 1'b0;
         step(7);
         i_btn[0] = 1'b1;
         step(1);
      end
      i_btn[0] = 1'b0;
      expect_evt(cyc + 10, 2'b01, 2'b00, 2'b00, 2'b01);
      step(30);
      i_btn[0] = 1'b1;
      expect_evt(cyc + 10, 2'b00, 2'b01, 2'b00, 2'b00);
      step(30);

      // auto-repeat while held; the strobe due at release must be suppressed
      i_repeat_en[0] = 1'b1;
      step(2);
      i_btn[0] = 1'b0;
      p = cyc + 10;
      expect_evt(p, 2'b01, 2'b00, 2'b00, 2'b01);
      for (int m = 0; m < 10; m++) expect_evt(p + 20 + 5 * m, 2'b00, 2'b00, 2'b01, 2'b01);
      step(70);
      i_btn[0] = 1'b1;
      expect_evt(cyc + 10, 2'b00, 2'b01, 2'b00, 2'b00);
      step(30);

      // repeat disabled at press, enabled mid-hold: no repeats
      i_repeat_en[0] = 1'b0;
      step(1);
      i_btn[0] = 1'b0;
      expect_evt(cyc + 10, 2'b01, 2'b00, 2'b00, 2'b01);
      step(25);
      i_repeat_en[0] = 1'b1;
      step(55);
      i_btn[0] = 1'b1;
      expect_evt(cyc + 10, 2'b00, 2'b01, 2'b00, 2'b00);
      step(30);
      i_repeat_en[0] = 1'b0;
      step(2);

      // both channels together
      i_btn = 2'b00;
      expect_evt(cyc + 10, 2'b11, 2'b00, 2'b00, 2'b11);
      step(30);
      i_btn = 2'b11;
      expect_evt(cyc + 10, 2'b00, 2'b11, 2'b00, 2'b00);
      step(30);

      // reset mid-count, button held through deassertion
      i_btn[0] = 1'b0;
      step(4);
      assert_reset("rst_midcount");
      step(3);
      i_repeat_en[0] = 1'b1;
      i_reset = 1'b1;
      p = cyc + 10;
      expect_evt(p, 2'b01, 2'b00, 2'b00, 2'b01);
      expect_evt(p + 20, 2'b00, 2'b00, 2'b01, 2'b01);
      expect_evt(p + 25, 2'b00, 2'b00, 2'b01, 2'b01);
      step(40);
      chk("pre_reset_repeat", 32'(o_repeat), 32'd1);
      chk("pre_reset_level", 32'(o_level), 32'd1);
      assert_reset("rst_rpt");
      i_btn = 2'b11;
      i_repeat_en = 2'b00;
      step(2);
      i_reset = 1'b1;
      step(20);

      chk("final_level", 32'(o_level), 32'd0);
      chk("leftover_events", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
